// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Serial 8N1 UART transmitter that drains bytes from an upstream FIFO with a
// registered read port. When the transmitter is idle and the FIFO is not
// empty, it pulses fifo_rd_en for one cycle. It captures fifo_dout during the
// following LOAD cycle and then shifts the byte out LSB first. The shifted
// frame is a start bit, eight data bits and a stop bit.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   fifo_empty - FIFO empty flag
//   fifo_dout  - FIFO read data, valid the cycle after a read strobe
//   fifo_rd_en - read strobe to the FIFO (combinational, IDLE only)
//   tx         - serial line, idle high, driven from a register
//   busy       - high while a byte is held or being shifted
//
// Parameter:
//   CLOCKS_PER_BIT - clock cycles per serial bit (baud divisor), >= 2

module fifo_uart_tx #(
  parameter int CLOCKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t       state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         bit_end;

  // The last cycle of every serial bit (start, data or stop).
  assign bit_end = (baud_q == BAUD_LAST);

  // The read strobe is gated by reset. A read issued in the same cycle as
  // reset would pop a byte that the transmitter then throws away.
  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !rst;

  assign tx   = tx_q;
  assign busy = busy_q;

  // Next-state logic for the frame sequencer. tx and busy are derived from
  // the next state and the next shift-register LSB. This lets the registers
  // present them in the same cycle the state takes effect. The line then
  // never glitches through combinational decode.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        shift_d = fifo_dout;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Single state register for the whole sequencer, with a synchronous reset.
  // Reset drops any byte in flight. That byte was already popped, so it is
  // lost rather than re-read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx with CLOCKS_PER_BIT = 4. A behavioural
// FIFO with a registered read port feeds the transmitter. A reference model
// predicts fifo_rd_en, busy and tx for every cycle from a schedule of frames.
// Each frame is described by its byte and the cycle at which its start bit
// begins.

module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int GAP   = FRAME + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO: the bench pushes bytes, and the DUT read strobe pops
  // them into a registered dout.
  logic [7:0] fifo_mem [0:63];
  int pushed_cnt = 0;
  int popped_cnt = 0;
  int rd_pulses  = 0;
  int bad_rd     = 0;

  assign fifo_empty = (pushed_cnt == popped_cnt);

  // Expected frames: byte value and the cycle at which its start bit begins.
  typedef struct packed {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t sched[$];

  fifo_uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Registered FIFO read port.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout  <= fifo_mem[popped_cnt];
      popped_cnt <= popped_cnt + 1;
    end
  end

  // Count read pulses, and count any read strobe raised against an empty FIFO.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) rd_pulses = rd_pulses + 1;
    if (fifo_rd_en && fifo_empty)  bad_rd    = bad_rd + 1;
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[pushed_cnt] = b;
    pushed_cnt = pushed_cnt + 1;
  endtask

  // Line level k cycles after the start bit begins. The line is 0 for the
  // start bit, then carries the data bits LSB first, then is high for the
  // stop bit and idle.
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k < CPB) return 1'b0;
    if (k < 9 * CPB) return b[(k - CPB) / CPB];
    return 1'b1;
  endfunction

  // Expected {fifo_rd_en, busy, tx} at cycle t of the current schedule. Each
  // frame follows this pattern:
  //   - The read strobe fires two cycles before the start bit.
  //   - busy rises one cycle before the start bit (LOAD).
  //   - busy falls when the stop bit ends.
  function automatic logic [2:0] ref_out(input int t);
    logic rd_e   = 1'b0;
    logic busy_e = 1'b0;
    logic tx_e   = 1'b1;
    foreach (sched[i]) begin
      int s = sched[i].start;
      if (t == s - 2) rd_e = 1'b1;
      if (t >= s - 1 && t < s + FRAME) busy_e = 1'b1;
      if (t >= s && t < s + FRAME) tx_e = line_bit(sched[i].data, t - s);
    end
    return {rd_e, busy_e, tx_e};
  endfunction

  // Reset held with the FIFO empty, then with the FIFO non-empty.
  // Releasing reset starts a normal frame.
  task automatic test_reset();
    logic [7:0] b;
    int p0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc=%0d {rd,busy,tx} got %b want 001", i, {fifo_rd_en, busy, tx});
      end
    end
    b = 8'($urandom);
    push_byte(b);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL reset_with_data cyc=%0d {rd,busy,tx} got %b want 001", i, {fifo_rd_en, busy, tx});
      end
    end
    p0 = rd_pulses;
    @(negedge clk);
    rst = 1'b0;
    sched.delete();
    sched.push_back('{data: b, start: 2});
    for (int t = 0; t <= GAP; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL after_reset t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    checks++;
    if (rd_pulses - p0 !== 1) begin
      errors++;
      $display("[TB] FAIL after_reset_pulses got %0d want 1", rd_pulses - p0);
    end
  endtask

  // A single 0x55 frame, with alternating data bits.
  task automatic test_single_byte();
    int p0 = rd_pulses;
    @(negedge clk);
    push_byte(8'h55);
    sched.delete();
    sched.push_back('{data: 8'h55, start: 2});
    for (int t = 0; t <= GAP; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL single_55 t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    checks++;
    if (rd_pulses - p0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_55_pulses got %0d want 1", rd_pulses - p0);
    end
  endtask

  // Two bytes queued together: their frames start 10*CPB+2 cycles apart.
  task automatic test_back_to_back();
    int p0 = rd_pulses;
    @(negedge clk);
    push_byte(8'hA3);
    push_byte(8'h0F);
    sched.delete();
    sched.push_back('{data: 8'hA3, start: 2});
    sched.push_back('{data: 8'h0F, start: 2 + GAP});
    for (int t = 0; t <= 2 * GAP; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL back_to_back t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    checks++;
    if (rd_pulses - p0 !== 2 || !fifo_empty) begin
      errors++;
      $display("[TB] FAIL back_to_back_pulses got %0d empty=%b want 2 empty=1", rd_pulses - p0, fifo_empty);
    end
  endtask

  // A byte that arrives mid-DATA waits for IDLE. It must not trigger an
  // early read.
  task automatic test_push_mid_frame();
    int p0 = rd_pulses;
    @(negedge clk);
    push_byte(8'hFF);
    sched.delete();
    sched.push_back('{data: 8'hFF, start: 2});
    sched.push_back('{data: 8'h01, start: 2 + GAP});
    for (int t = 0; t <= 2 * GAP; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 2 + CPB + 10) push_byte(8'h01);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL push_mid_frame t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    checks++;
    if (rd_pulses - p0 !== 2) begin
      errors++;
      $display("[TB] FAIL push_mid_frame_pulses got %0d want 2", rd_pulses - p0);
    end
  endtask

  // One-cycle reset during data bit 3 of 0x00. The line returns high at
  // once. A new byte then starts a clean frame, and the aborted byte is not
  // re-read.
  task automatic test_reset_mid_frame();
    logic [7:0] c;
    int p0 = rd_pulses;
    @(negedge clk);
    push_byte(8'h00);
    sched.delete();
    sched.push_back('{data: 8'h00, start: 2});
    for (int t = 0; t <= 2 + CPB + 3 * CPB + 1; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 2 + CPB + 3 * CPB + 1) rst = 1'b1;
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL reset_mid_frame t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    c = 8'($urandom);
    push_byte(c);
    sched.delete();
    sched.push_back('{data: c, start: 2});
    for (int t = 0; t <= GAP; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL after_mid_reset t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
    checks++;
    if (rd_pulses - p0 !== 2) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame_pulses got %0d want 2", rd_pulses - p0);
    end
  endtask

  // Four random bytes queued at once, sent as a continuous stream.
  task automatic test_random_stream();
    sched.delete();
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      logic [7:0] b = 8'($urandom);
      push_byte(b);
      sched.push_back('{data: b, start: 2 + f * GAP});
    end
    for (int t = 0; t <= 4 * GAP; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
        errors++;
        $display("[TB] FAIL random_stream t=%0d {rd,busy,tx} got %b want %b", t, {fifo_rd_en, busy, tx}, ref_out(t));
      end
    end
  endtask

  // Random bytes with random idle gaps between them.
  task automatic test_random_gaps();
    for (int n = 0; n < 5; n++) begin
      logic [7:0] b = 8'($urandom);
      int gap = int'($urandom_range(0, 4));
      @(negedge clk);
      push_byte(b);
      sched.delete();
      sched.push_back('{data: b, start: 2});
      for (int t = 0; t <= GAP; t++) begin
        if (t > 0) @(negedge clk);
        #1;
        checks++;
        if ({fifo_rd_en, busy, tx} !== ref_out(t)) begin
          errors++;
          $display("[TB] FAIL random_gaps n=%0d t=%0d {rd,busy,tx} got %b want %b", n, t, {fifo_rd_en, busy, tx}, ref_out(t));
        end
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        checks++;
        if ({fifo_rd_en, busy, tx} !== 3'b001) begin
          errors++;
          $display("[TB] FAIL random_gaps_idle n=%0d g=%0d {rd,busy,tx} got %b want 001", n, g, {fifo_rd_en, busy, tx});
        end
      end
    end
  endtask

  // Every pushed byte was popped exactly once, and no read ever hit an empty
  // FIFO.
  task automatic test_fifo_protocol();
    @(negedge clk); #1;
    checks++;
    if (popped_cnt !== pushed_cnt || bad_rd !== 0) begin
      errors++;
      $display("[TB] FAIL fifo_protocol popped=%0d pushed=%0d empty_reads=%0d want popped=pushed empty_reads=0", popped_cnt, pushed_cnt, bad_rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_push_mid_frame();
    test_reset_mid_frame();
    test_random_stream();
    test_random_gaps();
    test_fifo_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial UART transmitter that drains bytes from the 8-bit `fifo` and sends each as an 8N1 frame on a single line. Sits directly downstream of the `fifo`: it watches the FIFO's `empty` flag, pulses the FIFO's `rd_en`, captures the registered `dout`, and serializes it. It pulls only when idle and never reads an empty FIFO.

## Interface
- `CLOCKS_PER_BIT`, default 868 — clock cycles per serial bit (baud divisor); legal range ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_dout`  input  8  FIFO `dout`; updates on the edge that samples `fifo_rd_en`=1 with `fifo_empty`=0, otherwise holds.
- `fifo_rd_en`  output  1  read strobe to FIFO `rd_en`.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  high while a byte is held or being shifted.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. `fifo_rd_en` = (state==IDLE) && !`fifo_empty` (combinational). If `fifo_empty`=0 → LOAD; else stay.
- LOAD (1 cycle): `fifo_dout` is valid; captured into 8-bit shift register at the edge leaving LOAD; bit counter and baud counter cleared → START.
- START: `tx`=0 for `CLOCKS_PER_BIT` cycles → DATA.
- DATA: 8 bits, LSB first, each held `CLOCKS_PER_BIT` cycles; shift register shifts right at end of each bit; after bit 7 → STOP.
- STOP: `tx`=1 for `CLOCKS_PER_BIT` cycles → IDLE.
- `busy`=1 in LOAD, START, DATA, STOP.
- `fifo_rd_en` is never high outside IDLE and never high while `fifo_empty`=1; exactly one pulse per frame.
- Baud counter width `$clog2(CLOCKS_PER_BIT)`; counts 0..`CLOCKS_PER_BIT`-1, wraps to 0 at bit boundary. Bit index is 3 bits, 0..7.
- `tx` is driven from a register (glitch-free); its value is a function of the current state and shift-register LSB only.

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0 while `rst`=1 (gated), counters=0, shift register=0.
- Edge E0: IDLE samples `fifo_empty`=0, FIFO pops. Cycle after E0: LOAD. Start bit `tx`=0 begins cycle after E0+1 and lasts exactly `CLOCKS_PER_BIT` cycles.
- Frame = 10×`CLOCKS_PER_BIT` cycles of line time; with the FIFO continuously non-empty, frame period = 10×`CLOCKS_PER_BIT` + 2 cycles (IDLE + LOAD add 2 high cycles after stop bit).
- FIFO becoming non-empty during START/DATA/STOP: ignored until IDLE; no read issued early.
- FIFO going empty mid-frame: no effect on current frame.
- Reset mid-frame: next cycle `tx`=1, IDLE; byte in progress is discarded (already popped, not re-read).
- `rst` and `fifo_empty`=0 in same cycle: no read, `fifo_rd_en`=0.

## Test plan
- Reset with FIFO empty, 20 cycles -> `tx`=1, `busy`=0, `fifo_rd_en` never asserted.
- `CLOCKS_PER_BIT`=4, write 0x55 into FIFO -> single `fifo_rd_en` pulse; `tx` = 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each 4 cycles; `busy` falls after stop.
- `CLOCKS_PER_BIT`=4, FIFO (ADDR_WIDTH=1) filled with 0xA3, 0x0F -> two frames, LSB-first data 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; frame starts 42 cycles apart; FIFO `empty`=1 after second pop.
- Write 0x01 to FIFO while a frame of 0xFF is mid-DATA -> no `fifo_rd_en` until IDLE; 0x01 frame follows with 2 idle-high cycles gap.
- Assert `rst` for 1 cycle during DATA bit 3 of 0x00 -> `tx`=1 next cycle, `busy`=0; FIFO non-empty afterwards -> fresh frame starts normally.
